// File: rtl/adc_capture_if.sv
// Capture-side bus of adc_capture: ADC pads, forwarded clocks and the
// sample stream presented to the DSP chain.
interface adc_capture_if #(
  parameter int DATA_W = 12
);
  logic              en;
  logic              ovr_clr;
  logic [DATA_W-1:0] ad1_data_in;
  logic [DATA_W-1:0] ad2_data_in;
  logic              ad1_otr;
  logic              ad2_otr;
  logic              ad1_clk;
  logic              ad2_clk;
  logic [DATA_W-1:0] ch1_out;
  logic [DATA_W-1:0] ch2_out;
  logic              out_valid;
  logic              running;
  logic [1:0]        ovr_sticky;
  logic [15:0]       sample_cnt;

  modport master (
    output en, ovr_clr, ad1_data_in, ad2_data_in, ad1_otr, ad2_otr,
    input  ad1_clk, ad2_clk, ch1_out, ch2_out, out_valid, running,
           ovr_sticky, sample_cnt
  );

  modport slave (
    input  en, ovr_clr, ad1_data_in, ad2_data_in, ad1_otr, ad2_otr,
    output ad1_clk, ad2_clk, ch1_out, ch2_out, out_valid, running,
           ovr_sticky, sample_cnt
  );
endinterface

// File: rtl/adc_capture.sv
// Two-channel ADC capture: forwarded sample clocks, pad capture, offset-binary
// to two's complement conversion and optional power-of-two boxcar decimation.
//
// state  | meaning
// IDLE   | capture off, accumulators cleared, waiting for en
// WARMUP | discarding WARMUP_CYC cycles of samples after enable
// RUN    | accumulating and emitting averaged sample pairs
module adc_capture #(
  parameter int DATA_W     = 12,
  parameter int LOG2_DEC   = 0,
  parameter int WARMUP_CYC = 8
) (
  input logic          sys_clk,
  input logic          rst,
  adc_capture_if.slave bus
);

  localparam int ACC_W = DATA_W + LOG2_DEC;
  localparam int PH_W  = (LOG2_DEC > 0) ? LOG2_DEC : 1;
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'((1 << LOG2_DEC) - 1);
  localparam logic [7:0]      WARM_LOAD = 8'(WARMUP_CYC - 1);

  typedef enum logic [1:0] {IDLE, WARMUP, RUN} state_t;

  state_t state_q, state_d;
  logic [7:0] warm_q, warm_d;

  logic [DATA_W-1:0]        s1_d1, s1_d2;
  logic [1:0]               s1_otr;
  logic signed [DATA_W-1:0] s2_d1, s2_d2;
  logic signed [ACC_W-1:0]  acc1_q, acc2_q, sum1, sum2;
  logic [PH_W-1:0]          phase_q;
  logic [DATA_W-1:0]        ch1_q, ch2_q;
  logic                     valid_q;
  logic [1:0]               sticky_q;
  logic [15:0]              cnt_q;
  logic                     ad1_fall_q, ad2_fall_q;
  logic                     run_en, warm_entry, phase_last;

  // ODDR with D1=0/D2=1: low after the rising edge, high after the falling edge
  always_ff @(negedge sys_clk or posedge rst) begin
    if (rst) begin
      ad1_fall_q <= 1'b0;
      ad2_fall_q <= 1'b0;
    end else begin
      ad1_fall_q <= 1'b1;
      ad2_fall_q <= 1'b1;
    end
  end

  assign bus.ad1_clk = sys_clk ? 1'b0 : ad1_fall_q;
  assign bus.ad2_clk = sys_clk ? 1'b0 : ad2_fall_q;

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      s1_d1  <= '0;
      s1_d2  <= '0;
      s1_otr <= '0;
      s2_d1  <= '0;
      s2_d2  <= '0;
    end else begin
      s1_d1  <= bus.ad1_data_in;
      s1_d2  <= bus.ad2_data_in;
      s1_otr <= {bus.ad2_otr, bus.ad1_otr};
      s2_d1  <= {~s1_d1[DATA_W-1], s1_d1[DATA_W-2:0]};
      s2_d2  <= {~s1_d2[DATA_W-1], s1_d2[DATA_W-2:0]};
    end
  end

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      warm_q  <= '0;
    end else begin
      state_q <= state_d;
      warm_q  <= warm_d;
    end
  end

  always_comb begin
    state_d = state_q;
    warm_d  = warm_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = WARMUP;
          warm_d  = WARM_LOAD;
        end
      end
      WARMUP: begin
        if (!bus.en)           state_d = IDLE;
        else if (warm_q == '0) state_d = RUN;
        else                   warm_d  = warm_q - 8'd1;
      end
      RUN: begin
        if (!bus.en) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A dropped enable in RUN discards the partial block without emitting
  assign run_en     = (state_q == RUN) && bus.en;
  assign warm_entry = (state_q == IDLE) && bus.en;
  assign phase_last = (phase_q == PH_LAST);
  assign sum1       = acc1_q + ACC_W'(s2_d1);
  assign sum2       = acc2_q + ACC_W'(s2_d2);

  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      acc1_q   <= '0;
      acc2_q   <= '0;
      phase_q  <= '0;
      ch1_q    <= '0;
      ch2_q    <= '0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
      sticky_q <= '0;
    end else begin
      valid_q <= 1'b0;
      if (run_en) begin
        if (phase_last) begin
          ch1_q   <= DATA_W'(sum1 >>> LOG2_DEC);
          ch2_q   <= DATA_W'(sum2 >>> LOG2_DEC);
          valid_q <= 1'b1;
          cnt_q   <= cnt_q + 16'd1;
          acc1_q  <= '0;
          acc2_q  <= '0;
          phase_q <= '0;
        end else begin
          acc1_q  <= sum1;
          acc2_q  <= sum2;
          phase_q <= phase_q + 1'b1;
        end
      end else begin
        acc1_q  <= '0;
        acc2_q  <= '0;
        phase_q <= '0;
        if (warm_entry) cnt_q <= '0;
      end
      // set has priority over a coincident clear
      sticky_q <= (sticky_q & ~{2{bus.ovr_clr}})
                | (s1_otr & {2{state_q != IDLE}});
    end
  end

  assign bus.ch1_out    = ch1_q;
  assign bus.ch2_out    = ch2_q;
  assign bus.out_valid  = valid_q;
  assign bus.running    = (state_q == RUN);
  assign bus.ovr_sticky = sticky_q;
  assign bus.sample_cnt = cnt_q;

endmodule

// File: tb/tb_adc_capture.sv
// Self-checking bench for adc_capture: a passthrough and a 4x-decimating
// instance share stimulus; expectations come from a sample-stream model.
module tb_adc_capture;
  localparam int DW = 12;

  logic sys_clk = 1'b0;
  logic rst     = 1'b1;
  logic en      = 1'b0;
  logic ovr_clr = 1'b0;
  logic ad1_otr = 1'b0;
  logic ad2_otr = 1'b0;
  logic [DW-1:0] ad1 = '0;
  logic [DW-1:0] ad2 = '0;

  int checks   = 0;
  int failures = 0;

  // pad values driven before edge k of a run (k=0 is the edge sampling en=1)
  logic [DW-1:0] p1 [0:63];
  logic [DW-1:0] p2 [0:63];

  adc_capture_if #(.DATA_W(DW)) if0 ();
  adc_capture_if #(.DATA_W(DW)) if2 ();

  assign if0.en = en;
  assign if0.ovr_clr = ovr_clr;
  assign if0.ad1_data_in = ad1;
  assign if0.ad2_data_in = ad2;
  assign if0.ad1_otr = ad1_otr;
  assign if0.ad2_otr = ad2_otr;
  assign if2.en = en;
  assign if2.ovr_clr = ovr_clr;
  assign if2.ad1_data_in = ad1;
  assign if2.ad2_data_in = ad2;
  assign if2.ad1_otr = ad1_otr;
  assign if2.ad2_otr = ad2_otr;

  adc_capture #(.DATA_W(DW), .LOG2_DEC(0), .WARMUP_CYC(8)) dut0 (
    .sys_clk(sys_clk), .rst(rst), .bus(if0.slave));
  adc_capture #(.DATA_W(DW), .LOG2_DEC(2), .WARMUP_CYC(8)) dut2 (
    .sys_clk(sys_clk), .rst(rst), .bus(if2.slave));

  always #5 sys_clk = ~sys_clk;

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int cvt(input logic [DW-1:0] x);
    return int'({20'd0, x}) - 2048;
  endfunction

  // floor of the mean of n consecutive converted pad samples
  function automatic logic [DW-1:0] avg(input int ch, input int first, input int n);
    int s;
    int q;
    s = 0;
    for (int i = 0; i < n; i++)
      s += cvt(ch == 1 ? p1[first+i] : p2[first+i]);
    if (s >= 0) q = s / n;
    else        q = -((-s + n - 1) / n);
    return DW'(q);
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      p1[i] = DW'($urandom);
      p2[i] = DW'($urandom);
    end
  endtask

  task automatic step(input int k);
    ad1 = p1[k];
    ad2 = p2[k];
    @(posedge sys_clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b0; ovr_clr = 1'b0;
    ad1_otr = 1'b0; ad2_otr = 1'b0; ad1 = '0; ad2 = '0;
    repeat (2) @(posedge sys_clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; ad1 = 12'hABC; ad2 = 12'h123; ad1_otr = 1'b1;
    @(posedge sys_clk);
    #1;
    checks++;
    if ({if0.ch1_out, if0.ch2_out, if0.out_valid, if0.running, if0.ovr_sticky, if0.sample_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_dut0 got=%h %h %b %b %b %h exp=all zero", if0.ch1_out, if0.ch2_out,
               if0.out_valid, if0.running, if0.ovr_sticky, if0.sample_cnt);
    end
    checks++;
    if ({if2.ch1_out, if2.ch2_out, if2.out_valid, if2.running, if2.ovr_sticky, if2.sample_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_dut2 got=%h %h %b %b %b %h exp=all zero", if2.ch1_out, if2.ch2_out,
               if2.out_valid, if2.running, if2.ovr_sticky, if2.sample_cnt);
    end
    @(negedge sys_clk);
    #1;
    checks++;
    if ({if0.ad1_clk, if0.ad2_clk} !== 2'b00) begin
      failures++;
      $display("FAIL reset_adclk_low got=%b exp=00", {if0.ad1_clk, if0.ad2_clk});
    end
    en = 1'b0; ad1_otr = 1'b0;
    rst = 1'b0;
    @(negedge sys_clk);
    #1;
    checks++;
    if ({if0.ad1_clk, if0.ad2_clk, if2.ad1_clk} !== 3'b111) begin
      failures++;
      $display("FAIL adclk_low_phase got=%b exp=111", {if0.ad1_clk, if0.ad2_clk, if2.ad1_clk});
    end
    @(posedge sys_clk);
    #1;
    checks++;
    if ({if0.ad1_clk, if0.ad2_clk} !== 2'b00) begin
      failures++;
      $display("FAIL adclk_high_phase got=%b exp=00", {if0.ad1_clk, if0.ad2_clk});
    end
    repeat (3) @(posedge sys_clk);
    #1;
    checks++;
    if (if0.running !== 1'b0 || if0.ovr_sticky !== 2'b00) begin
      failures++;
      $display("FAIL idle_after_reset got=run %b sticky %b exp=0 00", if0.running, if0.ovr_sticky);
    end
  endtask

  task automatic test_passthrough();
    logic [DW-1:0] e1, e2;
    fill_random();
    p1[7] = 12'h800; p1[8] = 12'hFFF; p1[9] = 12'h000; p1[10] = 12'h7FF;
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 30; k++) begin
      step(k);
      if (k >= 9) begin
        e1 = DW'(cvt(p1[k-2]));
        e2 = DW'(cvt(p2[k-2]));
        checks++;
        if ({if0.out_valid, if0.running, if0.ch1_out, if0.ch2_out} !== {1'b1, 1'b1, e1, e2}) begin
          failures++;
          $display("FAIL passthrough k=%0d got=%b %b %h %h exp=1 1 %h %h", k, if0.out_valid,
                   if0.running, if0.ch1_out, if0.ch2_out, e1, e2);
        end
        checks++;
        if (if0.sample_cnt !== 16'(k - 8)) begin
          failures++;
          $display("FAIL passthrough_cnt k=%0d got=%0d exp=%0d", k, if0.sample_cnt, k - 8);
        end
      end
    end
  endtask

  task automatic test_warmup();
    fill_random();
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      step(k);
      checks++;
      if ({if0.running, if2.running} !== {2{k >= 8}}) begin
        failures++;
        $display("FAIL warmup_running k=%0d got=%b%b exp=%b", k, if0.running, if2.running, k >= 8);
      end
      checks++;
      if (if0.out_valid !== (k >= 9) || if2.out_valid !== 1'b0 ||
          if0.sample_cnt !== ((k >= 9) ? 16'(k - 8) : 16'd0)) begin
        failures++;
        $display("FAIL warmup_valid k=%0d got=%b %b cnt %0d exp=%b 0", k, if0.out_valid,
                 if2.out_valid, if0.sample_cnt, k >= 9);
      end
    end
  endtask

  task automatic test_decimate();
    logic [DW-1:0] l1, l2;
    logic          ev;
    fill_random();
    p1[7]  = 12'h801; p1[8]  = 12'h803; p1[9]  = 12'h805; p1[10] = 12'h807;
    p1[11] = 12'h7FF; p1[12] = 12'h7FE; p1[13] = 12'h7FE; p1[14] = 12'h7FE;
    l1 = '0; l2 = '0;
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 41; k++) begin
      step(k);
      if (k >= 8) begin
        ev = (k >= 12) && ((k - 8) % 4 == 0);
        if (ev) begin
          l1 = avg(1, k - 5, 4);
          l2 = avg(2, k - 5, 4);
        end
        checks++;
        if ({if2.out_valid, if2.ch1_out, if2.ch2_out} !== {ev, l1, l2}) begin
          failures++;
          $display("FAIL decimate k=%0d got=%b %h %h exp=%b %h %h", k, if2.out_valid,
                   if2.ch1_out, if2.ch2_out, ev, l1, l2);
        end
        checks++;
        if (if2.sample_cnt !== 16'((k - 8) / 4)) begin
          failures++;
          $display("FAIL decimate_cnt k=%0d got=%0d exp=%0d", k, if2.sample_cnt, (k - 8) / 4);
        end
      end
    end
  endtask

  task automatic test_enable_drop();
    logic [DW-1:0] e1;
    fill_random();
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 19; k++) step(k);
    checks++;
    if (if2.sample_cnt !== 16'd2) begin
      failures++;
      $display("FAIL drop_precount got=%0d exp=2", if2.sample_cnt);
    end
    en = 1'b0;
    for (int k = 19; k < 23; k++) begin
      step(k);
      checks++;
      if ({if2.running, if2.out_valid, if2.sample_cnt} !== {1'b0, 1'b0, 16'd2}) begin
        failures++;
        $display("FAIL drop_idle k=%0d got=%b %b %0d exp=0 0 2", k, if2.running,
                 if2.out_valid, if2.sample_cnt);
      end
    end
    fill_random();
    en = 1'b1;
    for (int k = 0; k < 13; k++) begin
      step(k);
      if (k < 12) begin
        checks++;
        if ({if2.running, if2.out_valid, if2.sample_cnt} !== {k >= 8, 1'b0, 16'd0}) begin
          failures++;
          $display("FAIL drop_rewarm k=%0d got=%b %b %0d exp=%b 0 0", k, if2.running,
                   if2.out_valid, if2.sample_cnt, k >= 8);
        end
      end else begin
        e1 = avg(1, 7, 4);
        checks++;
        if ({if2.out_valid, if2.ch1_out, if2.sample_cnt} !== {1'b1, e1, 16'd1}) begin
          failures++;
          $display("FAIL drop_first_out got=%b %h %0d exp=1 %h 1", if2.out_valid,
                   if2.ch1_out, if2.sample_cnt, e1);
        end
      end
    end
  endtask

  task automatic test_overrange();
    fill_random();
    apply_reset();
    en = 1'b1;
    for (int k = 0; k < 10; k++) step(k);
    ad2_otr = 1'b1;
    step(10);
    ad2_otr = 1'b0;
    checks++;
    if (if0.ovr_sticky !== 2'b00) begin
      failures++;
      $display("FAIL ovr_latency got=%b exp=00", if0.ovr_sticky);
    end
    step(11);
    step(12);
    step(13);
    checks++;
    if ({if0.ovr_sticky, if2.ovr_sticky} !== 4'b1010) begin
      failures++;
      $display("FAIL ovr_set_hold got=%b %b exp=10 10", if0.ovr_sticky, if2.ovr_sticky);
    end
    ad2_otr = 1'b1;
    step(14);
    ad2_otr = 1'b0;
    ovr_clr = 1'b1;
    step(15);
    ovr_clr = 1'b0;
    checks++;
    if (if0.ovr_sticky !== 2'b10) begin
      failures++;
      $display("FAIL ovr_set_wins got=%b exp=10", if0.ovr_sticky);
    end
    ovr_clr = 1'b1;
    step(16);
    ovr_clr = 1'b0;
    checks++;
    if (if0.ovr_sticky !== 2'b00) begin
      failures++;
      $display("FAIL ovr_clear got=%b exp=00", if0.ovr_sticky);
    end
    ad1_otr = 1'b1;
    step(17);
    ad1_otr = 1'b0;
    step(18);
    checks++;
    if (if0.ovr_sticky !== 2'b01) begin
      failures++;
      $display("FAIL ovr_ch1 got=%b exp=01", if0.ovr_sticky);
    end
    ovr_clr = 1'b1;
    en = 1'b0;
    step(19);
    ovr_clr = 1'b0;
    step(20);
    ad1_otr = 1'b1; ad2_otr = 1'b1;
    step(21);
    step(22);
    ad1_otr = 1'b0; ad2_otr = 1'b0;
    step(23);
    checks++;
    if ({if0.ovr_sticky, if0.running} !== 3'b000) begin
      failures++;
      $display("FAIL ovr_idle_ignored got=%b run %b exp=00 0", if0.ovr_sticky, if0.running);
    end
  endtask

  task automatic test_async_reset();
    logic [DW-1:0] e1, e2;
    for (int i = 0; i < 64; i++) begin
      p1[i] = 12'h900 + DW'($urandom_range(0, 255));
      p2[i] = 12'h100 + DW'($urandom_range(0, 255));
    end
    apply_reset();
    en = 1'b1;
    ad2_otr = 1'b1;
    for (int k = 0; k < 14; k++) step(k);
    ad2_otr = 1'b0;
    e1 = DW'(cvt(p1[11]));
    e2 = avg(1, 7, 4);
    checks++;
    if ({if0.out_valid, if0.ch1_out, if2.ch1_out, if0.ovr_sticky} !== {1'b1, e1, e2, 2'b10}) begin
      failures++;
      $display("FAIL arst_pre got=%b %h %h %b exp=1 %h %h 10", if0.out_valid, if0.ch1_out,
               if2.ch1_out, if0.ovr_sticky, e1, e2);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({if0.ch1_out, if0.ch2_out, if0.out_valid, if0.running, if0.ovr_sticky, if0.sample_cnt,
         if2.ch1_out, if2.ch2_out, if2.running, if2.sample_cnt} !== '0) begin
      failures++;
      $display("FAIL arst_immediate got=%h %h %b %b %b %h %h %h %b %h exp=all zero",
               if0.ch1_out, if0.ch2_out, if0.out_valid, if0.running, if0.ovr_sticky,
               if0.sample_cnt, if2.ch1_out, if2.ch2_out, if2.running, if2.sample_cnt);
    end
    @(negedge sys_clk);
    #1;
    checks++;
    if ({if0.ad1_clk, if0.ad2_clk, if2.ad1_clk, if2.ad2_clk} !== 4'b0000) begin
      failures++;
      $display("FAIL arst_adclk got=%b exp=0000", {if0.ad1_clk, if0.ad2_clk, if2.ad1_clk, if2.ad2_clk});
    end
    en = 1'b0;
    @(posedge sys_clk);
    #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge sys_clk);
      #1;
      checks++;
      if ({if0.running, if0.out_valid, if0.sample_cnt} !== '0) begin
        failures++;
        $display("FAIL arst_idle k=%0d got=%b %b %0d exp=0 0 0", k, if0.running,
                 if0.out_valid, if0.sample_cnt);
      end
    end
    en = 1'b1;
    for (int k = 0; k < 9; k++) begin
      step(k);
      if (k >= 7) begin
        checks++;
        if (if0.running !== (k >= 8)) begin
          failures++;
          $display("FAIL arst_rewarm k=%0d got=%b exp=%b", k, if0.running, k >= 8);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_passthrough();
    test_warmup();
    test_decimate();
    test_enable_drop();
    test_overrange();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adc_capture.md
Name: adc_capture

Overview:
- Receive-side counterpart of the DAC output driver: a two-channel ADC front end.
- Forwards the ADC sample clocks via ODDR and captures two offset-binary parallel ADC buses plus out-of-range flags in IOB registers.
- Converts samples to two's complement and optionally decimates each channel by a power-of-two boxcar average.
- Presents aligned sample pairs with a valid strobe to the downstream DSP chain on sys_clk.

Parameters:
DATA_W, 12, ADC sample width (input and output).
LOG2_DEC, 0, log2 of decimation/averaging factor, range 0..6.
WARMUP_CYC, 8, sys_clk cycles of discarded samples after enable (1..255).

Ports:
sys_clk  in  1  system clock; ADC clocks derive from it.
rst  in  1  asynchronous active-high reset.
en  in  1  capture enable, level sensitive.
ovr_clr  in  1  clears ovr_sticky, single-cycle pulse.
ad1_data_in  in  DATA_W  ADC1 bus, offset binary.
ad2_data_in  in  DATA_W  ADC2 bus, offset binary.
ad1_otr  in  1  ADC1 out-of-range flag.
ad2_otr  in  1  ADC2 out-of-range flag.
ad1_clk  out  1  ADC1 sample clock, ODDR-forwarded (D1=0, D2=1).
ad2_clk  out  1  ADC2 sample clock, ODDR-forwarded (D1=0, D2=1).
ch1_out  out  DATA_W  channel 1 sample, signed two's complement.
ch2_out  out  DATA_W  channel 2 sample, signed two's complement.
out_valid  out  1  ch1_out/ch2_out valid this cycle.
running  out  1  high in RUN state.
ovr_sticky  out  2  bit0 = ADC1 overrange seen, bit1 = ADC2.
sample_cnt  out  16  count of out_valid pulses since last WARMUP entry; wraps.

Behaviour:
- Reset: every output and register is 0, FSM in IDLE. ad?_clk ODDRs use async reset on rst, so the clocks are held low during reset.
- Pipeline (all stages clocked every cycle):
  - S1: IOB registers capture data and otr.
  - S2: invert MSB (offset binary to two's complement).
  - S3: accumulator/output register.
  - Latency: a pad value captured at edge k appears on ch?_out after edge k+2.
- FSM:
  - IDLE: accumulators and phase held at 0; out_valid=0. If en=1, go to WARMUP.
  - WARMUP: counter runs 0..WARMUP_CYC-1 and all samples are discarded. Go to RUN when the counter reaches WARMUP_CYC-1. sample_cnt cleared on entry.
  - RUN: accumulate S2 samples; phase counts 0..2^LOG2_DEC-1.
  - en=0 in WARMUP or RUN: go to IDLE next edge; partial accumulation discarded, no out_valid emitted. A later en=1 re-runs full WARMUP.
- Decimation, per channel, identical timing on both channels:
  - Accumulator width DATA_W+LOG2_DEC, signed.
  - At phase = 2^LOG2_DEC-1: ch?_out <= (acc + sample) >>> LOG2_DEC (arithmetic shift, truncation toward minus infinity). out_valid <= 1, acc <= 0, phase <= 0, all in the same edge.
  - Other phases: acc <= acc + sample, out_valid <= 0.
  - ch?_out holds its last value between valid pulses.
  - LOG2_DEC=0: pure passthrough; out_valid stays high every RUN cycle.
- First accumulated sample is the S2 value present on the first RUN cycle. First out_valid occurs 2^LOG2_DEC cycles after RUN entry.
- running = (state == RUN).
- ovr_sticky[i]:
  - Set when S1-registered otr_i = 1 and state != IDLE.
  - Cleared by ovr_clr.
  - Simultaneous set and clear: set wins.
- sample_cnt increments on each out_valid; 0xFFFF wraps to 0x0000.
- Async rst mid-operation: outputs go to 0 immediately, without a clock edge. After rst release, the block sits in IDLE until en is sampled high.

Test Plan:
1. Passthrough, LOG2_DEC=0, WARMUP_CYC=8, en held high.
   - Stimulus: pad 0x800, 0xFFF, 0x000, 0x7FF.
   - Response: ch1_out 0x000, 0x7FF, 0x800, 0xFFF, each 2 edges after capture; out_valid continuous once running=1; ch2 identical with its own data.
2. Decimate, LOG2_DEC=2.
   - Stimulus A: ch1 inputs 0x801, 0x803, 0x805, 0x807 (+1, +3, +5, +7). Response: ch1_out=0x004, single out_valid pulse; next pulse exactly 4 cycles later.
   - Stimulus B: inputs -1, -2, -2, -2 (0x7FF, 0x7FE, 0x7FE, 0x7FE). Response: sum -7, ch1_out=0xFFE (-2).
3. Warmup timing.
   - Stimulus: en rises at cycle 0.
   - Response: running=1 from cycle WARMUP_CYC+1; out_valid and sample_cnt stay 0 until then.
4. Enable drop mid-block, LOG2_DEC=2.
   - Stimulus: en=0 after 2 RUN samples, then re-asserted.
   - Response: no out_valid; running=0 next edge; re-enable repeats the 8-cycle warmup; first output averages 4 fresh samples; sample_cnt restarts at 0.
5. Overrange.
   - Stimulus: 1-cycle ad2_otr pulse in RUN. Response: ovr_sticky=2'b10 and it stays set.
   - Stimulus: ovr_clr coincident with a new ad2_otr. Response: bit remains 1.
   - Stimulus: ovr_clr alone. Response: 2'b00.
   - Stimulus: otr pulse in IDLE. Response: ignored.
6. Async reset.
   - Stimulus: rst asserted between edges during RUN with outputs nonzero.
   - Response: all outputs 0 before the next edge; ad1_clk/ad2_clk held low; after release, IDLE until en is sampled high.
